axil_ctrl_regs: RTL and testbench

- Parametrised AXI4-Lite control/status register block for N independent engine channels.
- Provides per-channel start pulses, busy tracking, a sticky done latch with write-1-to-clear, interrupt masking, byte-strobed scratch registers and a version register.
- Implements the AXI4-Lite handshakes natively, with independent AW/W acceptance.
- Sits between the PCIe/AXI interconnect and the datapath engines.

---
 rtl/axil_ctrl_pkg.sv | 43 ++++
 rtl/ctrl_chan.sv | 44 ++++
 rtl/axil_ctrl_regs.sv | 233 +++++++++++++++++++++++
 tb/tb_axil_ctrl_regs.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/axil_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_ctrl_pkg
// Description : Register indices, response codes and address decode helper
//               shared by the AXI4-Lite control/status register block.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_ctrl_pkg;

  localparam logic [31:0] REG_START    = 32'd0;
  localparam logic [31:0] REG_DONE     = 32'd1;
  localparam logic [31:0] REG_IRQ_EN   = 32'd2;
  localparam logic [31:0] REG_VERSION  = 32'd3;
  localparam logic [31:0] REG_SCRATCH0 = 32'd4;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    K_START   = 3'd0,
    K_DONE    = 3'd1,
    K_IRQ_EN  = 3'd2,
    K_VERSION = 3'd3,
    K_SCRATCH = 3'd4,
    K_INVALID = 3'd5
  } reg_kind_e;

  function automatic reg_kind_e decode_idx(input logic [31:0] idx,
                                           input logic [31:0] num_scratch);
    reg_kind_e kind;
    kind = K_INVALID;
    if (idx == REG_START)        kind = K_START;
    else if (idx == REG_DONE)    kind = K_DONE;
    else if (idx == REG_IRQ_EN)  kind = K_IRQ_EN;
    else if (idx == REG_VERSION) kind = K_VERSION;
    else if ((idx >= REG_SCRATCH0) && (idx < REG_SCRATCH0 + num_scratch))
      kind = K_SCRATCH;
    return kind;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_chan.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_chan
// Description : One engine channel: start pulse, busy tracking, sticky done.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_chan (
  input  logic clk,
  input  logic resetn,
  input  logic i_start_req,
  input  logic i_done,
  input  logic i_clr,
  output logic o_start,
  output logic o_busy,
  output logic o_done
);

  logic r_start;
  logic r_busy;
  logic r_done;
  logic w_fire;

  // A request for a channel already running is dropped here.
  assign w_fire = i_start_req & ~r_busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_start <= w_fire;
      // Completion coinciding with the start pulse must not clear busy.
      r_busy  <= w_fire | (r_busy & ~(i_done & ~r_start));
      r_done  <= i_done | (r_done & ~i_clr);
    end
  end

  assign o_start = r_start;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule
`default_nettype wire

// File: rtl/axil_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module      : axil_ctrl_regs
// Description : AXI4-Lite control/status registers for NUM_CHAN engines.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_ctrl_regs
  import axil_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CHAN    = 4,
  parameter int unsigned NUM_SCRATCH = 2,
  parameter logic [31:0] ADDR_MASK   = 32'h0000_007F,
  parameter logic [31:0] VERSION     = 32'h0001_0000
) (
  input  logic                clk,
  input  logic                resetn,
  output logic [NUM_CHAN-1:0] start,
  input  logic [NUM_CHAN-1:0] done_in,
  output logic [NUM_CHAN-1:0] busy,
  output logic                irq,
  input  logic [31:0]         S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [2:0]          S_AXI_AWPROT,
  input  logic [31:0]         S_AXI_WDATA,
  input  logic [3:0]          S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [31:0]         S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  input  logic [2:0]          S_AXI_ARPROT,
  output logic [31:0]         S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY
);

  localparam logic [31:0] c_num_scratch = 32'(NUM_SCRATCH);

  // ---------------------------------------------------------------- write path
  logic                r_aw_held;
  logic [31:0]         r_aw_addr;
  logic                r_w_held;
  logic [31:0]         r_w_data;
  logic [3:0]          r_w_strb;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic [NUM_CHAN-1:0] r_irq_en;
  logic                r_irq;
  logic [NUM_SCRATCH-1:0][31:0] r_scratch;

  logic                w_awready;
  logic                w_wready;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_wr_fire;
  logic [31:0]         w_wr_addr;
  logic [31:0]         w_wr_data;
  logic [3:0]          w_wr_strb;
  logic [31:0]         w_wr_idx;
  reg_kind_e           w_wr_kind;
  logic [NUM_CHAN-1:0] w_wr_bits;
  logic [1:0]          w_wr_resp;
  logic [NUM_CHAN-1:0] w_start_req;
  logic [NUM_CHAN-1:0] w_done_clr;
  logic [NUM_CHAN-1:0] w_busy;
  logic [NUM_CHAN-1:0] w_done;
  logic                w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // Ready lines are gated by reset so they read 0 while reset is asserted.
  assign w_awready = resetn & ~r_aw_held;
  assign w_wready  = resetn & ~r_w_held;
  assign w_aw_hs   = S_AXI_AWVALID & w_awready;
  assign w_w_hs    = S_AXI_WVALID & w_wready;

  // Bypass the holding registers so a same-cycle AW+W executes on this edge.
  assign w_wr_addr = r_aw_held ? r_aw_addr : S_AXI_AWADDR;
  assign w_wr_data = r_w_held  ? r_w_data  : S_AXI_WDATA;
  assign w_wr_strb = r_w_held  ? r_w_strb  : S_AXI_WSTRB;
  assign w_wr_fire = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs) & ~r_bvalid;
  assign w_wr_idx  = (w_wr_addr & ADDR_MASK) >> 2;
  assign w_wr_kind = decode_idx(w_wr_idx, c_num_scratch);
  assign w_wr_bits = w_wr_data[NUM_CHAN-1:0];

  always_comb begin
    w_start_req = '0;
    w_done_clr  = '0;
    w_wr_resp   = OKAY;
    case (w_wr_kind)
      K_START: begin
        w_start_req = w_wr_fire ? w_wr_bits : '0;
        if (|(w_wr_bits & w_busy)) w_wr_resp = SLVERR;
      end
      K_DONE:    w_done_clr = w_wr_fire ? w_wr_bits : '0;
      K_VERSION: w_wr_resp  = SLVERR;
      K_INVALID: w_wr_resp  = DECERR;
      default:   w_wr_resp  = OKAY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
    end else begin
      if (w_wr_fire) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_addr <= S_AXI_AWADDR;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_w_data <= S_AXI_WDATA;
          r_w_strb <= S_AXI_WSTRB;
        end
      end
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_resp;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
        r_bresp  <= OKAY;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_irq_en  <= '0;
      r_scratch <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr_fire && (w_wr_kind == K_IRQ_EN)) r_irq_en <= w_wr_bits;
      for (int s = 0; s < NUM_SCRATCH; s++) begin
        if (w_wr_fire && (w_wr_kind == K_SCRATCH) &&
            (w_wr_idx == REG_SCRATCH0 + 32'(s))) begin
          for (int b = 0; b < 4; b++) begin
            if (w_wr_strb[b]) r_scratch[s][8*b +: 8] <= w_wr_data[8*b +: 8];
          end
        end
      end
      r_irq <= |(w_done & r_irq_en);
    end
  end

  // ------------------------------------------------------------------ channels
  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
    ctrl_chan u_chan (
      .clk         (clk),
      .resetn      (resetn),
      .i_start_req (w_start_req[i]),
      .i_done      (done_in[i]),
      .i_clr       (w_done_clr[i]),
      .o_start     (start[i]),
      .o_busy      (w_busy[i]),
      .o_done      (w_done[i])
    );
  end

  // ----------------------------------------------------------------- read path
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_arready;
  logic        w_ar_hs;
  logic [31:0] w_rd_idx;
  reg_kind_e   w_rd_kind;
  logic [31:0] w_rd_data;
  logic [1:0]  w_rd_resp;

  assign w_arready = resetn & ~r_rvalid;
  assign w_ar_hs   = S_AXI_ARVALID & w_arready;
  assign w_rd_idx  = (S_AXI_ARADDR & ADDR_MASK) >> 2;
  assign w_rd_kind = decode_idx(w_rd_idx, c_num_scratch);

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = OKAY;
    case (w_rd_kind)
      K_START:   w_rd_data[NUM_CHAN-1:0] = w_busy;
      K_DONE:    w_rd_data[NUM_CHAN-1:0] = w_done;
      K_IRQ_EN:  w_rd_data[NUM_CHAN-1:0] = r_irq_en;
      K_VERSION: w_rd_data = VERSION;
      K_SCRATCH: begin
        for (int s = 0; s < NUM_SCRATCH; s++) begin
          if (w_rd_idx == REG_SCRATCH0 + 32'(s)) w_rd_data = r_scratch[s];
        end
      end
      default:   w_rd_resp = DECERR;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  assign busy          = w_busy;
  assign irq           = r_irq;
  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axil_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_ctrl_regs
// Description : Scoreboard bench for the AXI4-Lite control/status registers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_ctrl_regs;

  localparam int NC = 4;

  logic          clk;
  logic          resetn;
  logic [NC-1:0] start;
  logic [NC-1:0] done_in;
  logic [NC-1:0] busy;
  logic          irq;
  logic [31:0]   AWADDR;
  logic          AWVALID;
  logic          AWREADY;
  logic [31:0]   WDATA;
  logic [3:0]    WSTRB;
  logic          WVALID;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;
  logic [31:0]   ARADDR;
  logic          ARVALID;
  logic          ARREADY;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY;

  int n_vec = 0;
  int n_bad = 0;

  logic [1:0]    q_bresp[$];
  logic [NC-1:0] q_start[$];
  logic [33:0]   q_rd[$];

  axil_ctrl_regs #(
    .NUM_CHAN(NC), .NUM_SCRATCH(2), .ADDR_MASK(32'h7F), .VERSION(32'h0001_0000)
  ) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .done_in(done_in), .busy(busy), .irq(irq),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_AWPROT(3'b000),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_ARPROT(3'b000),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // W is presented first; AW follows aw_dly cycles later. done_pulse is driven
  // on done_in during the first cycle.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly,
                           input logic [NC-1:0] done_pulse,
                           input logic [1:0] exp_resp, input logic [NC-1:0] exp_start);
    bit aw_done = 0;
    bit w_done  = 0;
    bit got_b   = 0;
    bit aw_acc, w_acc;
    int cyc = 0;
    q_bresp.push_back(exp_resp);
    q_start.push_back(exp_start);
    @(negedge clk);
    WDATA = data; WSTRB = strb; WVALID = 1'b1; done_in = done_pulse;
    while (!got_b && cyc < 50) begin
      if (w_done && !aw_done) begin
        chk("wready_hold", 64'(WREADY), 64'd0);
        chk("b_before_aw", 64'(BVALID), 64'd0);
      end
      if (cyc == aw_dly && !aw_done) begin
        AWADDR = addr; AWVALID = 1'b1;
      end
      aw_acc = AWVALID && AWREADY;
      w_acc  = WVALID && WREADY;
      @(negedge clk);
      done_in = '0;
      if (aw_acc) begin AWVALID = 1'b0; aw_done = 1; end
      if (w_acc)  begin WVALID  = 1'b0; w_done  = 1; end
      if (BVALID) got_b = 1;
      cyc++;
    end
    if (!got_b) begin
      chk("b_timeout", 64'd0, 64'd1);
      void'(q_bresp.pop_front());
      void'(q_start.pop_front());
    end else begin
      chk("bresp", 64'(BRESP), 64'(q_bresp.pop_front()));
      chk("start_pulse", 64'(start), 64'(q_start.pop_front()));
      @(negedge clk);
      chk("start_clear", 64'(start), 64'd0);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    int cyc = 0;
    logic [33:0] e;
    q_rd.push_back({exp_resp, exp_data});
    @(negedge clk);
    ARADDR = addr; ARVALID = 1'b1;
    while (!ARREADY && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!ARREADY) chk("ar_timeout", 64'd0, 64'd1);
    @(negedge clk);
    ARVALID = 1'b0;
    chk("rvalid", 64'(RVALID), 64'd1);
    e = q_rd.pop_front();
    chk("rdata", 64'(RDATA), 64'(e[31:0]));
    chk("rresp", 64'(RRESP), 64'(e[33:32]));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({start, busy, irq, AWREADY, WREADY, ARREADY, BVALID, BRESP,
                RVALID, RRESP, RDATA});
  endfunction

  initial begin
    resetn = 1'b0; done_in = '0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b1; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    resetn = 1'b1;

    axi_read(32'h0C, 32'h0001_0000, 2'd0);

    // start pulses, busy drop and SLVERR for busy channels
    axi_write(32'h00, 32'h5, 4'hF, 0, '0, 2'd0, 4'b0101);
    axi_read(32'h00, 32'h5, 2'd0);
    axi_write(32'h00, 32'h3, 4'hF, 0, '0, 2'd2, 4'b0010);
    axi_read(32'h00, 32'h7, 2'd0);
    axi_write(32'h00, 32'hF0, 4'hF, 0, '0, 2'd0, 4'b0000);

    // done latch, irq and W1C
    axi_write(32'h08, 32'h1, 4'hF, 0, '0, 2'd0, 4'b0000);
    @(negedge clk); done_in = 4'b0001;
    @(negedge clk); done_in = '0;
    chk("busy_after_done", 64'(busy), 64'h6);
    chk("irq_lag", 64'(irq), 64'd0);
    @(negedge clk);
    chk("irq_set", 64'(irq), 64'd1);
    axi_read(32'h04, 32'h1, 2'd0);
    axi_write(32'h04, 32'h1, 4'hF, 0, '0, 2'd0, 4'b0000);
    chk("irq_clear", 64'(irq), 64'd0);
    axi_read(32'h04, 32'h0, 2'd0);
    axi_write(32'h04, 32'h1, 4'hF, 0, 4'b0001, 2'd0, 4'b0000);
    axi_read(32'h04, 32'h1, 2'd0);

    // byte strobes with W leading AW by three cycles
    axi_write(32'h10, 32'h0, 4'hF, 0, '0, 2'd0, 4'b0000);
    axi_write(32'h10, 32'hAABB_CCDD, 4'b0010, 3, '0, 2'd0, 4'b0000);
    axi_read(32'h10, 32'h0000_CC00, 2'd0);

    // back-pressure on B
    BREADY = 1'b0;
    axi_write(32'h14, 32'h1111_1111, 4'hF, 0, '0, 2'd0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bvalid_hold", 64'(BVALID), 64'd1);
    end
    AWADDR = 32'h14; AWVALID = 1'b1; WDATA = 32'h2222_2222; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("awready_full", 64'(AWREADY), 64'd0);
    chk("wready_full", 64'(WREADY), 64'd0);
    axi_read(32'h14, 32'h1111_1111, 2'd0);
    BREADY = 1'b1;
    @(negedge clk);
    chk("b_gap", 64'(BVALID), 64'd0);
    @(negedge clk);
    chk("b_second", 64'({BVALID, BRESP}), 64'b100);
    axi_read(32'h14, 32'h2222_2222, 2'd0);

    // error responses
    axi_read(32'h24, 32'h0, 2'd3);
    axi_write(32'h24, 32'hFFFF_FFFF, 4'hF, 0, '0, 2'd3, 4'b0000);
    axi_write(32'h0C, 32'h1234, 4'hF, 0, '0, 2'd2, 4'b0000);
    axi_read(32'h0C, 32'h0001_0000, 2'd0);
    axi_read(32'h8C, 32'h0001_0000, 2'd0);

    // asynchronous reset mid-transaction
    axi_write(32'h00, 32'h9, 4'hF, 0, '0, 2'd0, 4'b1001);
    chk("busy_all", 64'(busy), 64'hF);
    @(negedge clk);
    AWADDR = 32'h10; AWVALID = 1'b1; WDATA = 32'h5555_5555; WSTRB = 4'hF; WVALID = 1'b1;
    #2 resetn = 1'b0;
    #1 chk("async_reset", all_outs(), 64'd0);
    AWVALID = 1'b0; WVALID = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    axi_read(32'h00, 32'h0, 2'd0);
    axi_read(32'h08, 32'h0, 2'd0);
    axi_read(32'h10, 32'h0, 2'd0);
    axi_write(32'h10, 32'h1234_5678, 4'hF, 0, '0, 2'd0, 4'b0000);
    axi_read(32'h10, 32'h1234_5678, 2'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
